// File: rtl/pc_fetch_gen_pkg.sv
// Shared types and constants for the IF-stage fetch-PC generator.
package pc_fetch_gen_pkg;

  localparam int unsigned DEFAULT_FETCH_WIDTH = 4;
  localparam logic [31:0] DEFAULT_RESET_PC    = 32'hbfc0_0000;
  localparam int unsigned INSN_BYTES          = 4;

  // NORMAL: regular fetch; DS_PEND: next group carries only a spilled delay slot
  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_DS_PEND = 1'b1
  } fetch_state_e;

  // Byte distance between consecutive fetch groups
  function automatic logic [31:0] group_stride(input int unsigned fetch_width);
    return 32'(INSN_BYTES * fetch_width);
  endfunction

endpackage

// File: rtl/pc_fetch_gen_slot_expander.sv
// Combinational expander: fetch PC -> per-slot PCs plus start-offset mask.
module pc_fetch_gen_slot_expander
  import pc_fetch_gen_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = DEFAULT_FETCH_WIDTH
) (
  input  logic [31:0]               pc,
  output logic [32*FETCH_WIDTH-1:0] pc_group,
  output logic [FETCH_WIDTH-1:0]    start_mask
);

  localparam int unsigned SLOT_W = $clog2(FETCH_WIDTH);

  logic [SLOT_W-1:0] start;

  assign start = pc[SLOT_W+1:2];

  // Replace the slot-index bits with each slot number; low two bits pass through
  always_comb begin
    pc_group   = '0;
    start_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      pc_group[32*i +: 32] = {pc[31:SLOT_W+2], SLOT_W'(i), pc[1:0]};
      start_mask[i]        = (SLOT_W'(i) >= start);
    end
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch-PC register with slot expansion, flush/BTB redirects and spilled delay-slot handling.
module pc_fetch_gen
  import pc_fetch_gen_pkg::*;
#(
  parameter int unsigned  FETCH_WIDTH = DEFAULT_FETCH_WIDTH,
  parameter logic [31:0]  RESET_PC    = DEFAULT_RESET_PC,
  localparam int unsigned SLOT_W      = $clog2(FETCH_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [31:0]               flush_target_i,
  input  logic                      out_ready_i,
  input  logic                      bp_taken_i,
  input  logic [SLOT_W-1:0]         bp_slot_i,
  input  logic [31:0]               bp_target_i,
  output logic                      out_valid_o,
  output logic [32*FETCH_WIDTH-1:0] pc_group_o,
  output logic [FETCH_WIDTH-1:0]    slot_valid_o,
  output logic                      delay_slot_o
);

  fetch_state_e            state_q, state_nxt;
  logic [31:0]             pc_q, pc_nxt;
  logic [31:0]             saved_q, saved_nxt;
  logic                    valid_q;
  logic                    fire;
  logic [31:0]             base_pc;
  logic [31:0]             seq_pc;
  logic                    bp_last_slot;
  logic [SLOT_W:0]         bp_limit;
  logic [FETCH_WIDTH-1:0]  start_mask;
  logic [FETCH_WIDTH-1:0]  bp_mask;

  pc_fetch_gen_slot_expander #(
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_expander (
    .pc         (pc_q),
    .pc_group   (pc_group_o),
    .start_mask (start_mask)
  );

  assign fire         = valid_q & out_ready_i & ~flush_i;
  assign base_pc      = {pc_q[31:SLOT_W+2], {(SLOT_W+2){1'b0}}};
  assign seq_pc       = base_pc + group_stride(FETCH_WIDTH);
  assign bp_last_slot = (bp_slot_i == SLOT_W'(FETCH_WIDTH - 1));
  // Widened by one bit so the slot after the last one does not wrap to 0
  assign bp_limit     = {1'b0, bp_slot_i} + (SLOT_W+1)'(1);

  assign out_valid_o  = valid_q;
  assign delay_slot_o = (state_q == ST_DS_PEND);

  // Keep slots up to and including the delay slot after a predicted-taken branch
  always_comb begin
    bp_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      bp_mask[i] = ~bp_taken_i | ((SLOT_W+1)'(i) <= bp_limit);
    end
  end

  // Per-slot valid mask; a spilled delay-slot group exposes slot 0 only
  always_comb begin
    slot_valid_o = '0;
    if (valid_q) begin
      case (state_q)
        ST_NORMAL:  slot_valid_o = start_mask & bp_mask;
        ST_DS_PEND: slot_valid_o = FETCH_WIDTH'(1);
        default:    slot_valid_o = '0;
      endcase
    end else begin
      slot_valid_o = '0;
    end
  end

  // Next-PC priority: flush > delay-slot advance > BTB redirect > sequential
  always_comb begin
    pc_nxt    = pc_q;
    saved_nxt = saved_q;
    state_nxt = state_q;
    if (flush_i) begin
      pc_nxt    = flush_target_i;
      state_nxt = ST_NORMAL;
    end else if (fire) begin
      case (state_q)
        ST_DS_PEND: begin
          pc_nxt    = saved_q;
          state_nxt = ST_NORMAL;
        end
        ST_NORMAL: begin
          if (bp_taken_i && bp_last_slot) begin
            pc_nxt    = seq_pc;
            saved_nxt = bp_target_i;
            state_nxt = ST_DS_PEND;
          end else if (bp_taken_i) begin
            pc_nxt = bp_target_i;
          end else begin
            pc_nxt = seq_pc;
          end
        end
        default: begin
          pc_nxt    = seq_pc;
          state_nxt = ST_NORMAL;
        end
      endcase
    end else begin
      pc_nxt = pc_q;
    end
  end

  // State registers; reset wins over flush, flush leaves one bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      saved_q <= 32'h0000_0000;
      state_q <= ST_NORMAL;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_nxt;
      saved_q <= saved_nxt;
      state_q <= state_nxt;
      valid_q <= ~flush_i;
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Randomized self-checking bench for pc_fetch_gen (FETCH_WIDTH 4 and 8 instances).
module tb_pc_fetch_gen;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [31:0]  flush_target;
  logic         ready;
  logic         bp_taken;
  logic [2:0]   bp_slot;
  logic [31:0]  bp_target;

  logic         v4, v8;
  logic [127:0] g4;
  logic [255:0] g8;
  logic [3:0]   m4;
  logic [7:0]   m8;
  logic         d4, d8;

  int n_checks = 0;
  int n_err    = 0;
  bit en       = 1'b0;

  // Behavioural model state, index 0 -> width 4, index 1 -> width 8
  logic [31:0] m_pc[2];
  logic [31:0] m_saved[2];
  bit          m_ds[2];
  bit          m_valid[2];

  pc_fetch_gen #(.FETCH_WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .flush_i(flush), .flush_target_i(flush_target),
    .out_ready_i(ready), .bp_taken_i(bp_taken), .bp_slot_i(bp_slot[1:0]),
    .bp_target_i(bp_target), .out_valid_o(v4), .pc_group_o(g4),
    .slot_valid_o(m4), .delay_slot_o(d4)
  );

  pc_fetch_gen #(.FETCH_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .flush_i(flush), .flush_target_i(flush_target),
    .out_ready_i(ready), .bp_taken_i(bp_taken), .bp_slot_i(bp_slot),
    .bp_target_i(bp_target), .out_valid_o(v8), .pc_group_o(g8),
    .slot_valid_o(m8), .delay_slot_o(d8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fw_of(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic logic [31:0] exp_pc(input int k, input int i);
    int w;
    w = fw_of(k);
    return (m_pc[k] & ~(32'(4 * w) - 32'd1)) + 32'(4 * i) + (m_pc[k] & 32'd3);
  endfunction

  function automatic logic [7:0] exp_mask(input int k);
    logic [7:0] m;
    int w, start, s;
    m = 8'd0;
    w = fw_of(k);
    s = int'(bp_slot) % w;
    start = int'((m_pc[k] >> 2) % 32'(w));
    if (!m_valid[k]) return 8'd0;
    if (m_ds[k]) return 8'd1;
    for (int i = 0; i < w; i++)
      if (i >= start && (!bp_taken || i <= s + 1)) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on the same edge the DUT samples
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int w = fw_of(k);
      automatic logic [31:0] nb = (m_pc[k] & ~(32'(4 * w) - 32'd1)) + 32'(4 * w);
      automatic int s = int'(bp_slot) % w;
      if (rst) begin
        m_pc[k] <= 32'hbfc0_0000; m_saved[k] <= 32'd0; m_ds[k] <= 1'b0; m_valid[k] <= 1'b0;
      end else if (flush) begin
        m_pc[k] <= flush_target; m_ds[k] <= 1'b0; m_valid[k] <= 1'b0;
      end else begin
        m_valid[k] <= 1'b1;
        if (m_valid[k] && ready) begin
          if (m_ds[k]) begin
            m_pc[k] <= m_saved[k]; m_ds[k] <= 1'b0;
          end else if (bp_taken && s == w - 1) begin
            m_pc[k] <= nb; m_saved[k] <= bp_target; m_ds[k] <= 1'b1;
          end else if (bp_taken) begin
            m_pc[k] <= bp_target;
          end else begin
            m_pc[k] <= nb;
          end
        end
      end
    end
  end

  // Compare process: every cycle, both instances, away from the active edge
  always @(negedge clk) begin
    if (en) begin
      chk("u4 out_valid", {31'd0, v4}, {31'd0, m_valid[0]});
      chk("u8 out_valid", {31'd0, v8}, {31'd0, m_valid[1]});
      chk("u4 delay_slot", {31'd0, d4}, {31'd0, m_ds[0]});
      chk("u8 delay_slot", {31'd0, d8}, {31'd0, m_ds[1]});
      chk("u4 slot_valid", {28'd0, m4}, {24'd0, exp_mask(0)});
      chk("u8 slot_valid", {24'd0, m8}, {24'd0, exp_mask(1)});
      for (int i = 0; i < 4; i++) chk($sformatf("u4 pc[%0d]", i), g4[32*i +: 32], exp_pc(0, i));
      for (int i = 0; i < 8; i++) chk($sformatf("u8 pc[%0d]", i), g8[32*i +: 32], exp_pc(1, i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    flush = 1'b1; flush_target = tgt;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_target = 32'd0; ready = 1'b0;
    bp_taken = 1'b0; bp_slot = 3'd0; bp_target = 32'd0;
    repeat (2) tick();
    en = 1'b1;
    rst = 1'b0; ready = 1'b1;

    // Reset, then sequential groups
    @(negedge clk);
    chk("lit rst valid", {31'd0, v4}, 32'd0);
    chk("lit rst pc", g4[31:0], 32'hbfc0_0000);
    tick(); @(negedge clk);
    chk("lit first valid", {31'd0, v4}, 32'd1);
    chk("lit seq0", g4[31:0], 32'hbfc0_0000);
    chk("lit seq mask", {28'd0, m4}, 32'h0000_000f);
    tick(); @(negedge clk);
    chk("lit seq1", g4[31:0], 32'hbfc0_0010);
    tick(); @(negedge clk);
    chk("lit seq2", g4[31:0], 32'hbfc0_0020);

    // Flush to a mid-group address
    tick();
    do_flush(32'h8000_0188);
    @(negedge clk);
    chk("lit flush bubble", {31'd0, v4}, 32'd0);
    tick(); @(negedge clk);
    chk("lit flush base", g4[31:0], 32'h8000_0180);
    chk("lit flush slot2", g4[95:64], 32'h8000_0188);
    chk("lit flush mask", {28'd0, m4}, 32'h0000_000c);

    // Predicted taken in slot 1
    tick();
    do_flush(32'h8000_0000);
    tick();
    bp_taken = 1'b1; bp_slot = 3'd1; bp_target = 32'h8000_1000;
    @(negedge clk);
    chk("lit bp1 mask", {28'd0, m4}, 32'h0000_0007);
    tick();
    bp_taken = 1'b0;
    @(negedge clk);
    chk("lit bp1 next", g4[31:0], 32'h8000_1000);

    // Predicted taken in the last slot: delay slot spills
    tick();
    do_flush(32'h8000_0000);
    tick();
    bp_taken = 1'b1; bp_slot = 3'd3; bp_target = 32'h8000_2004;
    tick();
    bp_taken = 1'b0;
    @(negedge clk);
    chk("lit ds pc", g4[31:0], 32'h8000_0010);
    chk("lit ds flag", {31'd0, d4}, 32'd1);
    chk("lit ds mask", {28'd0, m4}, 32'h0000_0001);
    tick(); @(negedge clk);
    chk("lit ds target", g4[63:32], 32'h8000_2004);
    chk("lit ds target mask", {28'd0, m4}, 32'h0000_000e);

    // Stall in DS_PEND, then flush
    tick();
    do_flush(32'h8000_0000);
    tick();
    bp_taken = 1'b1; bp_slot = 3'd3; bp_target = 32'h8000_2004;
    tick();
    bp_taken = 1'b0; ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("lit stall pc", g4[31:0], 32'h8000_0010);
      chk("lit stall ds", {31'd0, d4}, 32'd1);
      tick();
    end
    do_flush(32'h9fc0_0380);
    ready = 1'b1;
    @(negedge clk);
    chk("lit stall bubble", {31'd0, v4}, 32'd0);
    chk("lit stall ds clr", {31'd0, d4}, 32'd0);
    tick(); @(negedge clk);
    chk("lit stall redirect", g4[31:0], 32'h9fc0_0380);

    // Address wrap on the width-8 instance
    tick();
    do_flush(32'hffff_fff0);
    tick(); @(negedge clk);
    chk("lit wrap mask8", {24'd0, m8}, 32'h0000_00f0);
    tick(); @(negedge clk);
    chk("lit wrap next8", g8[31:0], 32'h0000_0000);
    chk("lit wrap next4", g4[31:0], 32'h0000_0000);

    // Reset during a stall
    ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("lit rst stall pc", g4[31:0], 32'hbfc0_0000);
    chk("lit rst stall valid", {31'd0, v8}, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst          = ($urandom_range(0, 299) == 0);
      flush        = ($urandom_range(0, 15) == 0);
      flush_target = $urandom();
      ready        = ($urandom_range(0, 3) != 0);
      bp_taken     = ($urandom_range(0, 2) == 0);
      bp_slot      = 3'($urandom_range(0, 7));
      bp_target    = $urandom();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
